decode_stage: RTL
=================

Name: decode_stage

Overview:
Registered, multi-lane RV64I decode stage between fetch and register-read/issue. Each cycle it accepts a fetch group of LANES 32-bit instructions and decodes every lane into register indices, register enables, a sign-extended immediate, funct fields and an illegal flag. A 2-entry output buffer (main register plus skid register) isolates fetch from issue backpressure. Flush and reset clear it.

Parameters:
LANES, 2, instructions per fetch group (1..4)
XLEN, 64, immediate and PC width

Ports:
clk  in  1  clock
reset  in  1  synchronous reset, active-high
flush  in  1  discard all buffered and incoming groups
in_valid  in  1  fetch group valid
in_ready  out  1  stage can accept a group this cycle
in_pc  in  XLEN  PC of lane 0
in_inst  in  32*LANES  lane i at [32*i+31:32*i]
in_mask  in  LANES  per-lane instruction present
out_valid  out  1  decoded group valid
out_ready  in  1  consumer takes group
out_pc  out  XLEN*LANES  per-lane PC
out_lane_valid  out  LANES  per-lane valid after kill
out_rs1 / out_rs2 / out_rd  out  5*LANES  register indices
out_en_rs1 / out_en_rs2 / out_en_rd  out  LANES each  register-use enables
out_imm  out  XLEN*LANES  sign-extended immediate
out_funct3  out  3*LANES  inst[14:12]
out_funct7  out  7*LANES  inst[31:25]
out_op  out  7*LANES  inst[6:0]
out_illegal  out  LANES  lane is an illegal instruction
perf_groups / perf_insts / perf_illegal  out  32 each  counters (see Optional Feature)

Behaviour:
- Clock is clk. Reset is synchronous and active-high on reset. Both buffer entries are cleared. out_valid=0 and in_ready=1 on the first cycle after reset. All out_* data registers are 0.
- Handshake: accept when in_valid&&in_ready; deliver when out_valid&&out_ready.
- Latency is 1 cycle. A group accepted in cycle N is visible on outputs in N+1 when the buffer was empty.
- in_ready = !skid_full. It is driven from registered state only, with no combinational path from out_ready.
- Buffer states:
  - EMPTY: accept goes to ONE.
  - ONE: accept with no deliver goes to TWO (new group into skid). Accept with deliver stays ONE (new group into main). Deliver only goes to EMPTY.
  - TWO: in_ready=0. Deliver moves skid to main and goes to ONE.
- Groups are delivered strictly in order.
- Flush has priority over everything. Next state is EMPTY and any simultaneous input group is dropped. Reset has priority over flush.
- Per-lane PC: out_pc[i] = in_pc + 4*i, modulo 2^XLEN.
- Field extraction: rs1=inst[19:15], rs2=inst[24:20], rd=inst[11:7]. Funct fields and op are always raw.
- Immediate formats, sign bit inst[31] extended to XLEN:
  - I = inst[31:20]
  - S = {inst[31:25], inst[11:7]}
  - SB = {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - U = {inst[31:12], 12'b0}
  - UJ = {inst[31], inst[19:12], inst[20], inst[30:21], 0}
- Opcode table (imm; en_rs1/en_rs2/en_rd):
  - LUI 0110111, AUIPC 0010111: U; 001
  - JAL 1101111: UJ; 001
  - JALR 1100111: I; 101
  - BRANCH 1100011: SB; 110
  - LOAD 0000011: I; 101
  - STORE 0100011: S; 110
  - OP_IMM 0010011, OP_IMM_32 0011011: I; 101
  - OP 0110011, OP_32 0111011: imm 0; 111
  - MISC_MEM 0001111, SYSTEM 1110011: imm 0; 000
- en_rd is forced to 0 when rd==0.
- An instruction is illegal when any of these hold:
  - its opcode is not in the table (this covers inst[1:0]!=11);
  - JALR with funct3!=000;
  - BRANCH with funct3 010 or 011;
  - LOAD with funct3 111;
  - STORE with funct3[2]=1.
- An illegal lane has imm=0 and all enables 0.
- Lane kill: out_lane_valid[i] = in_mask[i] && no lane j<i is both present and illegal. The first illegal lane itself stays valid, with out_illegal set.
- A group with in_mask=0 is still accepted and delivered, with all lane_valid bits 0.

Optional Feature:
- Macro: DECODE_PERF_EN.
- When defined, three 32-bit wrapping counters are cleared by reset (not by flush) and incremented on each delivery:
  - perf_groups += 1;
  - perf_insts += popcount(out_lane_valid);
  - perf_illegal += popcount(out_lane_valid & out_illegal).
- When undefined, the ports remain and are tied to 0, with no counter logic.

Test Plan:
- LANES=2, lane0 0xFFF00093 (addi x1,x0,-1), lane1 0xFE208EE3 (beq x1,x2,-4), in_pc=0x1000 -> next cycle out_valid=1.
  - lane0: rd=1, rs1=0, en=101, imm=0xFFFF_FFFF_FFFF_FFFF, pc 0x1000.
  - lane1: rs1=1, rs2=2, en=110, imm=0xFFFF_FFFF_FFFF_FFFC, pc 0x1004.
- lane0 0x800002B7 (lui x5,0x80000) -> imm=0xFFFF_FFFF_8000_0000, rd=5, en=001. lane0 0x00000013 (nop) -> en_rd=0.
- lane0 0x00000000, lane1 0x00000013, mask=11 -> lane0 illegal=1, en=000, imm=0; lane1 lane_valid=0.
- out_ready=0, in_valid=1 for 4 cycles -> exactly 2 groups accepted, in_ready=0 from the cycle after the second accept. Then out_ready=1 -> groups delivered in acceptance order, in_ready returns 1 one cycle after the first deliver.
- Buffer TWO, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, dropped group never appears. Reset asserted in state ONE -> same result.
- With DECODE_PERF_EN: deliver 3 groups (masks 11, 01, 11, one illegal lane) -> perf_groups=3, perf_insts=5, perf_illegal=1. A flush leaves the counts unchanged.

Source files
------------

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//   Registered multi-lane RV64I decode stage sitting between fetch and
//   register-read/issue. Every cycle it can accept one fetch group of LANES
//   32-bit instructions and decodes each lane into register indices, register
//   enables, a sign-extended immediate, raw funct/opcode fields and an illegal
//   flag. A two-entry output buffer (main + skid) keeps in_ready a function of
//   registered state only, so fetch never sees a combinational path from the
//   consumer's out_ready.
//
// Optional feature macro: DECODE_PERF_EN
//   Defined   -> three 32-bit wrapping delivery counters (groups, valid lanes,
//                valid illegal lanes), cleared by reset only.
//   Undefined -> perf_* ports are tied to zero and no counter logic exists.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   flush               drop every buffered group and any incoming group
//   in_valid/in_ready   fetch-side handshake
//   in_pc               PC of lane 0
//   in_inst             lane i instruction at [32*i+31:32*i]
//   in_mask             per-lane instruction present
//   out_valid/out_ready issue-side handshake
//   out_pc              per-lane PC (in_pc + 4*i)
//   out_lane_valid      per-lane valid after killing lanes behind an illegal one
//   out_rs1/rs2/rd      register indices, 5 bits per lane
//   out_en_rs1/rs2/rd   register-use enables
//   out_imm             sign-extended immediate, XLEN bits per lane
//   out_funct3/funct7/op raw instruction fields
//   out_illegal         lane holds an illegal instruction
//   perf_groups/insts/illegal  delivery counters (see macro above)
// ---------------------------------------------------------------------------
module decode_stage #(
  parameter int LANES = 2,
  parameter int XLEN  = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       in_pc,
  input  logic [32*LANES-1:0]   in_inst,
  input  logic [LANES-1:0]      in_mask,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN*LANES-1:0] out_pc,
  output logic [LANES-1:0]      out_lane_valid,
  output logic [5*LANES-1:0]    out_rs1,
  output logic [5*LANES-1:0]    out_rs2,
  output logic [5*LANES-1:0]    out_rd,
  output logic [LANES-1:0]      out_en_rs1,
  output logic [LANES-1:0]      out_en_rs2,
  output logic [LANES-1:0]      out_en_rd,
  output logic [XLEN*LANES-1:0] out_imm,
  output logic [3*LANES-1:0]    out_funct3,
  output logic [7*LANES-1:0]    out_funct7,
  output logic [7*LANES-1:0]    out_op,
  output logic [LANES-1:0]      out_illegal,
  output logic [31:0]           perf_groups,
  output logic [31:0]           perf_insts,
  output logic [31:0]           perf_illegal
);

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ONE,
    S_TWO
  } state_e;

  // Opcode-dependent part of one lane's decode.
  typedef struct packed {
    logic            en_rs1;
    logic            en_rs2;
    logic            en_rd;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } lane_dec_t;

  // One fully decoded fetch group, laid out so each field maps straight
  // onto its flattened output port.
  typedef struct packed {
    logic [LANES-1:0][XLEN-1:0] pc;
    logic [LANES-1:0]           lane_valid;
    logic [LANES-1:0][4:0]      rs1;
    logic [LANES-1:0][4:0]      rs2;
    logic [LANES-1:0][4:0]      rd;
    logic [LANES-1:0]           en_rs1;
    logic [LANES-1:0]           en_rs2;
    logic [LANES-1:0]           en_rd;
    logic [LANES-1:0][XLEN-1:0] imm;
    logic [LANES-1:0][2:0]      funct3;
    logic [LANES-1:0][6:0]      funct7;
    logic [LANES-1:0][6:0]      op;
    logic [LANES-1:0]           illegal;
  } group_t;

  function automatic lane_dec_t decode_lane(input logic [31:0] inst);
    lane_dec_t       d;
    logic [2:0]      f3;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    f3    = inst[14:12];
    imm_i = {{(XLEN-12){inst[31]}}, inst[31:20]};
    imm_s = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
    imm_b = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    imm_u = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};
    imm_j = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    d = '0;
    case (inst[6:0])
      OPC_LUI, OPC_AUIPC: begin
        d.imm   = imm_u;
        d.en_rd = 1'b1;
      end
      OPC_JAL: begin
        d.imm   = imm_j;
        d.en_rd = 1'b1;
      end
      OPC_JALR: begin
        d.imm     = imm_i;
        d.en_rs1  = 1'b1;
        d.en_rd   = 1'b1;
        d.illegal = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        d.imm     = imm_b;
        d.en_rs1  = 1'b1;
        d.en_rs2  = 1'b1;
        d.illegal = (f3[2:1] == 2'b01);   // funct3 010/011 are unassigned
      end
      OPC_LOAD: begin
        d.imm     = imm_i;
        d.en_rs1  = 1'b1;
        d.en_rd   = 1'b1;
        d.illegal = (f3 == 3'b111);
      end
      OPC_STORE: begin
        d.imm     = imm_s;
        d.en_rs1  = 1'b1;
        d.en_rs2  = 1'b1;
        d.illegal = f3[2];
      end
      OPC_OP_IMM, OPC_OP_IMM_32: begin
        d.imm    = imm_i;
        d.en_rs1 = 1'b1;
        d.en_rd  = 1'b1;
      end
      OPC_OP, OPC_OP_32: begin
        d.en_rs1 = 1'b1;
        d.en_rs2 = 1'b1;
        d.en_rd  = 1'b1;
      end
      OPC_MISC_MEM, OPC_SYSTEM: ;
      default: d.illegal = 1'b1;         // also catches inst[1:0] != 2'b11
    endcase
    if (d.illegal) begin
      d.imm    = '0;
      d.en_rs1 = 1'b0;
      d.en_rs2 = 1'b0;
      d.en_rd  = 1'b0;
    end
    if (inst[11:7] == 5'd0) d.en_rd = 1'b0;
    return d;
  endfunction

  state_e    state_q, state_d;
  group_t    main_q, main_d;
  group_t    skid_q, skid_d;
  group_t    dec;
  lane_dec_t lane_dec;
  logic      killed;
  logic      accept, deliver;

  assign out_valid = (state_q != S_EMPTY);
  assign in_ready  = (state_q != S_TWO);
  assign accept    = in_valid && in_ready;
  assign deliver   = out_valid && out_ready;

  // Decode the incoming group. A lane behind the first present illegal lane
  // is killed; the illegal lane itself stays valid so issue can trap on it.
  always_comb begin
    // NOTE: every variable written here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    dec      = '0;
    lane_dec = '0;
    killed   = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      lane_dec          = decode_lane(in_inst[32*i +: 32]);
      dec.pc[i]         = in_pc + XLEN'(4 * i);
      dec.rs1[i]        = in_inst[32*i+15 +: 5];
      dec.rs2[i]        = in_inst[32*i+20 +: 5];
      dec.rd[i]         = in_inst[32*i+7 +: 5];
      dec.funct3[i]     = in_inst[32*i+12 +: 3];
      dec.funct7[i]     = in_inst[32*i+25 +: 7];
      dec.op[i]         = in_inst[32*i +: 7];
      dec.en_rs1[i]     = lane_dec.en_rs1;
      dec.en_rs2[i]     = lane_dec.en_rs2;
      dec.en_rd[i]      = lane_dec.en_rd;
      dec.imm[i]        = lane_dec.imm;
      dec.illegal[i]    = lane_dec.illegal;
      dec.lane_valid[i] = in_mask[i] && !killed;
      if (in_mask[i] && lane_dec.illegal) killed = 1'b1;
    end
  end

  // Output buffer control. Main always holds the oldest group; skid only
  // fills when main is stalled, which preserves delivery order.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            main_d  = dec;
            state_d = S_ONE;
          end
        end
        S_ONE: begin
          if (accept && deliver) begin
            main_d = dec;
          end else if (accept) begin
            skid_d  = dec;
            state_d = S_TWO;
          end else if (deliver) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: begin
          if (deliver) begin
            main_d  = skid_q;
            state_d = S_ONE;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q <= S_EMPTY;
      // NOTE: the data registers are reset too, so outputs read as zero
      // straight after reset instead of stale or unknown contents.
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign out_pc         = main_q.pc;
  assign out_lane_valid = main_q.lane_valid;
  assign out_rs1        = main_q.rs1;
  assign out_rs2        = main_q.rs2;
  assign out_rd         = main_q.rd;
  assign out_en_rs1     = main_q.en_rs1;
  assign out_en_rs2     = main_q.en_rs2;
  assign out_en_rd      = main_q.en_rd;
  assign out_imm        = main_q.imm;
  assign out_funct3     = main_q.funct3;
  assign out_funct7     = main_q.funct7;
  assign out_op         = main_q.op;
  assign out_illegal    = main_q.illegal;

`ifdef DECODE_PERF_EN
  function automatic logic [31:0] popcount(input logic [LANES-1:0] v);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < LANES; i++) n = n + 32'(v[i]);
    return n;
  endfunction

  logic [31:0] perf_groups_q, perf_insts_q, perf_illegal_q;

  // Counters follow delivered groups only; flush deliberately leaves them.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_groups_q  <= '0;
      perf_insts_q   <= '0;
      perf_illegal_q <= '0;
    end else if (deliver) begin
      perf_groups_q  <= perf_groups_q + 32'd1;
      perf_insts_q   <= perf_insts_q + popcount(main_q.lane_valid);
      perf_illegal_q <= perf_illegal_q + popcount(main_q.lane_valid & main_q.illegal);
    end
  end

  assign perf_groups  = perf_groups_q;
  assign perf_insts   = perf_insts_q;
  assign perf_illegal = perf_illegal_q;
`else
  assign perf_groups  = '0;
  assign perf_insts   = '0;
  assign perf_illegal = '0;
`endif

endmodule
